div8_restoring: RTL and testbench

DIV8_RESTORING -- requirements
Module: div8_restoring

---
 rtl/div8_restoring.sv | 145 ++++++++++++++
 tb/tb_div8_restoring.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/div8_restoring.sv
// ----------------------------------------------------------------------------
// div8_restoring
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock, so a division takes WIDTH cycles. A zero divisor skips the
//   iteration and reports saturated results right away.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   begin a division (only honoured in IDLE)
//   dividend     in   [WIDTH] unsigned numerator, sampled with start
//   divisor      in   [WIDTH] unsigned denominator, sampled with start
//   busy         out  division in progress
//   done         out  one-cycle pulse, results valid
//   quotient     out  [WIDTH] unsigned quotient (all ones on divide by zero)
//   remainder    out  [WIDTH] unsigned remainder (dividend on divide by zero)
//   div_by_zero  out  the sampled divisor was zero
// ----------------------------------------------------------------------------
module div8_restoring #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_quo, w_quo_nxt;   // holds the dividend, shifted out as quotient bits shift in
    logic [WIDTH-1:0] r_rem, w_rem_nxt;   // partial remainder
    logic [WIDTH-1:0] r_dvs, w_dvs_nxt;   // latched divisor
    logic [CW-1:0]    r_cnt, w_cnt_nxt;   // iterations left
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_dbz,  w_dbz_nxt;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_trial;
    logic             w_ge;

    // The partial remainder is always below the divisor, so the shifted value
    // is below 2*divisor. Hence the WIDTH+1 bit difference is exact whenever
    // it is non-negative, and its MSB is set exactly when it went negative.
    always_comb begin
        w_shift = {r_rem, r_quo[WIDTH-1]};
        w_trial = w_shift - {1'b0, r_dvs};
        w_ge    = ~w_trial[WIDTH];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_quo_nxt   = r_quo;
        w_rem_nxt   = r_rem;
        w_dvs_nxt   = r_dvs;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_dbz_nxt   = r_dbz;

        unique case (r_state)
            IDLE: begin
                w_done_nxt = 1'b0;
                if (start) begin
                    if (divisor != '0) begin
                        w_quo_nxt   = dividend;
                        w_dvs_nxt   = divisor;
                        w_rem_nxt   = '0;
                        w_cnt_nxt   = CW'(WIDTH);
                        w_dbz_nxt   = 1'b0;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = RUN;
                    end else begin
                        w_quo_nxt   = '1;
                        w_rem_nxt   = dividend;
                        w_dbz_nxt   = 1'b1;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};
                w_rem_nxt = w_ge ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_quo   <= w_quo_nxt;
            r_rem   <= w_rem_nxt;
            r_dvs   <= w_dvs_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dbz   <= w_dbz_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div8_restoring.sv
// ----------------------------------------------------------------------------
// tb_div8_restoring
//   Scoreboard bench for div8_restoring: the driver pushes the expected
//   result of each accepted division; the monitor pops and compares on done.
// ----------------------------------------------------------------------------
module tb_div8_restoring;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_err = 0;

    div8_restoring #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Monitor: compare each done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                m_e = sb.pop_front();
                chk("quotient",    int'(quotient),    int'(m_e.q));
                chk("remainder",   int'(remainder),   int'(m_e.r));
                chk("div_by_zero", int'(div_by_zero), int'(m_e.z));
            end
        end
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        if (b == 8'd0) begin
            e.q = 8'hFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic wait_idle();
        @(negedge clk);
        while (busy || done) @(negedge clk);
    endtask

    // Wait (bounded) for done after the start edge; returns edges since the
    // start edge and the number of busy cycles seen on the way.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = 0;
        nbusy = 0;
        while (!done && lat < 40) begin
            nbusy += int'(busy);
            @(posedge clk);
            #1 lat++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    task automatic div_op(input logic [7:0] a, input logic [7:0] b, input bit chk_tim);
        int lat;
        int nbusy;
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1 start = 1'b0;
        // scramble operands: the result in flight must not follow them
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        wait_done(lat, nbusy);
        if (chk_tim) begin
            chk("latency",     lat,   (b == 8'd0) ? 0 : 8);
            chk("busy_cycles", nbusy, (b == 8'd0) ? 0 : 8);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nbusy;
        logic [7:0] a;
        logic [7:0] b;

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy),        0);
        chk("rst_done", int'(done),        0);
        chk("rst_q",    int'(quotient),    0);
        chk("rst_r",    int'(remainder),   0);
        chk("rst_dbz",  int'(div_by_zero), 0);
        @(negedge clk) rst = 1'b0;

        // directed cases
        div_op(8'd100, 8'd7,  1'b1);
        div_op(8'd255, 8'd1,  1'b1);
        div_op(8'd5,   8'd9,  1'b1);
        div_op(8'd200, 8'd0,  1'b1);
        div_op(8'd0,   8'd255, 1'b1);
        div_op(8'd255, 8'd255, 1'b1);

        // start during RUN is dropped
        wait_idle();
        start    = 1'b1;
        dividend = 8'd255;
        divisor  = 8'd16;
        sb.push_back(model(8'd255, 8'd16));
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nbusy);
        chk("ignore_q", int'(quotient),  15);
        chk("ignore_r", int'(remainder), 15);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_q",    int'(quotient),  15);
        chk("hold_r",    int'(remainder), 15);
        chk("idle_busy", int'(busy),      0);

        // asynchronous reset mid-RUN, with start held during reset
        wait_idle();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", int'(busy),        0);
        chk("arst_done", int'(done),        0);
        chk("arst_q",    int'(quotient),    0);
        chk("arst_r",    int'(remainder),   0);
        chk("arst_dbz",  int'(div_by_zero), 0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_busy", int'(busy), 0);
        chk("rst_start_done", int'(done), 0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        div_op(8'd50, 8'd5, 1'b1);

        // back-to-back random traffic
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            div_op(a, b, 1'b1);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
